// File: rtl/ex_ctrl.sv
// ex_ctrl: commits interrupts/exceptions/ERET from the WB stage into CP0,
// flushes the pipeline, waits for the bus to drain, then redirects fetch.
module ex_ctrl #(
  parameter logic [31:0] EX_ENTRY   = 32'hbfc00380,
  parameter logic [4:0]  NO_EX_CODE = 5'h1f
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic [4:0]  ws_ex_code,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_pc_error,
  input  logic        ws_eret,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  input  logic        mem_busy,
  input  logic        redirect_ready,
  output logic [4:0]  ex_code,
  output logic        bd,
  output logic        eret,
  output logic        pc_error,
  output logic [31:0] epc_pc,
  output logic [31:0] badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_REDIR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  ex_code_q, ex_code_d;
  logic        bd_q, bd_d;
  logic        eret_q, eret_d;
  logic        pc_error_q, pc_error_d;
  logic [31:0] epc_pc_q, epc_pc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        busy_q, busy_d;

  logic        int_pend_c;
  logic        has_ex_c;
  logic        unused_c;

  // Interrupt pending: enabled, not at exception level, and an unmasked IP bit.
  assign int_pend_c = cp0_status[0] & ~cp0_status[1] &
                      (|(cp0_cause[15:8] & cp0_status[15:8]));
  assign has_ex_c   = (ws_ex_code != NO_EX_CODE);

  // CP0 bits not involved in the interrupt decision.
  assign unused_c = ^{cp0_cause[31:16], cp0_cause[7:0],
                      cp0_status[31:16], cp0_status[7:2]};

  // Next-state and next-output logic; strobes default back to idle values.
  always_comb begin
    state_d          = state_q;
    ex_code_d        = NO_EX_CODE;
    bd_d             = 1'b0;
    eret_d           = 1'b0;
    pc_error_d       = 1'b0;
    epc_pc_d         = 32'd0;
    badvaddr_d       = 32'd0;
    flush_d          = flush_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    busy_d           = busy_q;

    case (state_q)
      S_IDLE: begin
        if (ws_valid && (int_pend_c || has_ex_c || ws_eret)) begin
          state_d = S_DRAIN;
          flush_d = 1'b1;
          busy_d  = 1'b1;
          if (int_pend_c || has_ex_c) begin
            // Interrupt wins over a pipeline exception; ERET is dropped.
            ex_code_d     = int_pend_c ? 5'd0 : ws_ex_code;
            bd_d          = ws_bd;
            pc_error_d    = ws_pc_error;
            epc_pc_d      = ws_pc;
            badvaddr_d    = ws_badvaddr;
            redirect_pc_d = EX_ENTRY;
          end else begin
            eret_d        = 1'b1;
            redirect_pc_d = cp0_epc;
          end
        end
      end
      S_DRAIN: begin
        if (!mem_busy) begin
          state_d          = S_REDIR;
          redirect_valid_d = 1'b1;
        end
      end
      S_REDIR: begin
        if (redirect_ready) begin
          state_d          = S_IDLE;
          redirect_valid_d = 1'b0;
          flush_d          = 1'b0;
          busy_d           = 1'b0;
          redirect_pc_d    = 32'd0;
        end
      end
      default: begin
        state_d          = S_IDLE;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
        busy_d           = 1'b0;
        redirect_pc_d    = 32'd0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      ex_code_q        <= NO_EX_CODE;
      bd_q             <= 1'b0;
      eret_q           <= 1'b0;
      pc_error_q       <= 1'b0;
      epc_pc_q         <= 32'd0;
      badvaddr_q       <= 32'd0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      ex_code_q        <= ex_code_d;
      bd_q             <= bd_d;
      eret_q           <= eret_d;
      pc_error_q       <= pc_error_d;
      epc_pc_q         <= epc_pc_d;
      badvaddr_q       <= badvaddr_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign ex_code        = ex_code_q;
  assign bd             = bd_q;
  assign eret           = eret_q;
  assign pc_error       = pc_error_q;
  assign epc_pc         = epc_pc_q;
  assign badvaddr       = badvaddr_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ex_ctrl.sv
// tb_ex_ctrl: directed vector table plus hand sequences for ex_ctrl.
module tb_ex_ctrl;

  logic        clk;
  logic        resetn;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_bd;
  logic [4:0]  ws_ex_code;
  logic [31:0] ws_badvaddr;
  logic        ws_pc_error;
  logic        ws_eret;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        mem_busy;
  logic        redirect_ready;
  logic [4:0]  ex_code;
  logic        bd;
  logic        eret;
  logic        pc_error;
  logic [31:0] epc_pc;
  logic [31:0] badvaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int total;
  int bad;

  ex_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_valid       (ws_valid),
    .ws_pc          (ws_pc),
    .ws_bd          (ws_bd),
    .ws_ex_code     (ws_ex_code),
    .ws_badvaddr    (ws_badvaddr),
    .ws_pc_error    (ws_pc_error),
    .ws_eret        (ws_eret),
    .cp0_cause      (cp0_cause),
    .cp0_status     (cp0_status),
    .cp0_epc        (cp0_epc),
    .mem_busy       (mem_busy),
    .redirect_ready (redirect_ready),
    .ex_code        (ex_code),
    .bd             (bd),
    .eret           (eret),
    .pc_error       (pc_error),
    .epc_pc         (epc_pc),
    .badvaddr       (badvaddr),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        bdi;
    logic [4:0]  exc;
    logic [31:0] bad;
    logic        pce;
    logic        er;
    logic [31:0] cause;
    logic [31:0] status;
    logic [31:0] epc;
    logic        e_commit;
    logic [4:0]  e_code;
    logic        e_eret;
    logic        e_bd;
    logic        e_pce;
    logic [31:0] e_epc;
    logic [31:0] e_bad;
    logic [31:0] e_rpc;
  } vec_t;

  localparam int unsigned NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_strobes_idle(input string tag);
    chk({tag, ".ex_code"},  32'(ex_code),  32'h1f);
    chk({tag, ".bd"},       32'(bd),       32'd0);
    chk({tag, ".eret"},     32'(eret),     32'd0);
    chk({tag, ".pc_error"}, 32'(pc_error), 32'd0);
    chk({tag, ".epc_pc"},   epc_pc,        32'd0);
    chk({tag, ".badvaddr"}, badvaddr,      32'd0);
  endtask

  task automatic chk_all_idle(input string tag);
    chk_strobes_idle(tag);
    chk({tag, ".flush"},   32'(flush),          32'd0);
    chk({tag, ".rvalid"},  32'(redirect_valid), 32'd0);
    chk({tag, ".busy"},    32'(busy),           32'd0);
  endtask

  task automatic clear_ws();
    ws_valid    = 1'b0;
    ws_pc       = 32'd0;
    ws_bd       = 1'b0;
    ws_ex_code  = 5'h1f;
    ws_badvaddr = 32'd0;
    ws_pc_error = 1'b0;
    ws_eret     = 1'b0;
    cp0_cause   = 32'd0;
    cp0_status  = 32'd0;
    cp0_epc     = 32'd0;
  endtask

  // Present a syscall at WB for one cycle; returns after the commit edge.
  task automatic commit_syscall(input logic [31:0] pc);
    @(posedge clk); #1;
    clear_ws();
    ws_valid   = 1'b1;
    ws_pc      = pc;
    ws_ex_code = 5'd8;
    @(posedge clk); #1;
    clear_ws();
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{32'hbfc00100, 1'b0, 5'd8,  32'd0,        1'b0, 1'b0, 32'd0,        32'd0,        32'd0,
                1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 32'hbfc00100, 32'd0,        32'hbfc00380};
    vecs[1] = '{32'hbfc00200, 1'b1, 5'd12, 32'd0,        1'b0, 1'b0, 32'h40008000, 32'h0000ff01, 32'd0,
                1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 32'hbfc00200, 32'd0,        32'hbfc00380};
    vecs[2] = '{32'hbfc00300, 1'b0, 5'h1f, 32'd0,        1'b0, 1'b0, 32'h40008000, 32'h0000ff03, 32'd0,
                1'b0, 5'h1f, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd0};
    vecs[3] = '{32'hbfc00400, 1'b0, 5'h1f, 32'd0,        1'b0, 1'b1, 32'd0,        32'h0000ff03, 32'hbfc01234,
                1'b1, 5'h1f, 1'b1, 1'b0, 1'b0, 32'd0,        32'd0,        32'hbfc01234};
    vecs[4] = '{32'hbfc00500, 1'b1, 5'd4,  32'h00001235, 1'b1, 1'b0, 32'd0,        32'd0,        32'd0,
                1'b1, 5'd4,  1'b0, 1'b1, 1'b1, 32'hbfc00500, 32'h00001235, 32'hbfc00380};
    vecs[5] = '{32'hbfc00600, 1'b0, 5'd5,  32'h0000aaa0, 1'b0, 1'b1, 32'd0,        32'd0,        32'hbfc01234,
                1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 32'hbfc00600, 32'h0000aaa0, 32'hbfc00380};
    vecs[6] = '{32'hbfc00700, 1'b0, 5'h1f, 32'd0,        1'b0, 1'b0, 32'h00008000, 32'h0000ff00, 32'd0,
                1'b0, 5'h1f, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd0};
    vecs[7] = '{32'hbfc00800, 1'b0, 5'h1f, 32'd0,        1'b0, 1'b0, 32'h00000200, 32'h00000101, 32'd0,
                1'b0, 5'h1f, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd0};
    vecs[8] = '{32'hbfc00900, 1'b0, 5'h1f, 32'd0,        1'b0, 1'b1, 32'h00000400, 32'h00000401, 32'hbfc01234,
                1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 32'hbfc00900, 32'd0,        32'hbfc00380};

    // Reset held with random inputs.
    resetn         = 1'b0;
    ws_valid       = 1'($urandom);
    ws_pc          = $urandom;
    ws_bd          = 1'($urandom);
    ws_ex_code     = 5'($urandom);
    ws_badvaddr    = $urandom;
    ws_pc_error    = 1'($urandom);
    ws_eret        = 1'($urandom);
    cp0_cause      = $urandom;
    cp0_status     = $urandom;
    cp0_epc        = $urandom;
    mem_busy       = 1'($urandom);
    redirect_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    chk_all_idle("reset");
    chk("reset.rpc", redirect_pc, 32'd0);
    clear_ws();
    mem_busy       = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_idle("post_reset");
    chk("post_reset.rpc", redirect_pc, 32'd0);

    // Table: one WB event per vector, immediate drain and redirect accept.
    for (int i = 0; i < int'(NV); i++) begin
      @(posedge clk); #1;
      ws_valid    = 1'b1;
      ws_pc       = vecs[i].pc;
      ws_bd       = vecs[i].bdi;
      ws_ex_code  = vecs[i].exc;
      ws_badvaddr = vecs[i].bad;
      ws_pc_error = vecs[i].pce;
      ws_eret     = vecs[i].er;
      cp0_cause   = vecs[i].cause;
      cp0_status  = vecs[i].status;
      cp0_epc     = vecs[i].epc;
      mem_busy    = 1'b0;
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      clear_ws();
      @(negedge clk);
      chk($sformatf("v%0d.ex_code", i),  32'(ex_code),  32'(vecs[i].e_code));
      chk($sformatf("v%0d.eret", i),     32'(eret),     32'(vecs[i].e_eret));
      chk($sformatf("v%0d.bd", i),       32'(bd),       32'(vecs[i].e_bd));
      chk($sformatf("v%0d.pc_error", i), 32'(pc_error), 32'(vecs[i].e_pce));
      chk($sformatf("v%0d.epc_pc", i),   epc_pc,        vecs[i].e_epc);
      chk($sformatf("v%0d.badvaddr", i), badvaddr,      vecs[i].e_bad);
      chk($sformatf("v%0d.flush", i),    32'(flush),    32'(vecs[i].e_commit));
      chk($sformatf("v%0d.busy", i),     32'(busy),     32'(vecs[i].e_commit));
      chk($sformatf("v%0d.rvalid0", i),  32'(redirect_valid), 32'd0);
      @(negedge clk);
      chk_strobes_idle($sformatf("v%0d.after", i));
      chk($sformatf("v%0d.rvalid", i),   32'(redirect_valid), 32'(vecs[i].e_commit));
      if (vecs[i].e_commit)
        chk($sformatf("v%0d.rpc", i), redirect_pc, vecs[i].e_rpc);
      @(negedge clk);
      chk_all_idle($sformatf("v%0d.done", i));
    end

    // Syscall with redirect_ready held off for two cycles.
    redirect_ready = 1'b0;
    commit_syscall(32'hbfc00100);
    @(negedge clk);
    chk("sys.ex_code", 32'(ex_code), 32'd8);
    chk("sys.epc_pc",  epc_pc,       32'hbfc00100);
    chk("sys.flush",   32'(flush),   32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("sys.rvalid%0d", k), 32'(redirect_valid), 32'd1);
      chk($sformatf("sys.rpc%0d", k),    redirect_pc,         32'hbfc00380);
      chk($sformatf("sys.flush%0d", k),  32'(flush),          32'd1);
      chk($sformatf("sys.busy%0d", k),   32'(busy),           32'd1);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    chk_all_idle("sys.done");

    // Drain: mem_busy high for three cycles, WB events ignored meanwhile.
    @(posedge clk); #1;
    mem_busy = 1'b1;
    commit_syscall(32'hbfc00abc);
    @(negedge clk);
    chk("drn.ex_code", 32'(ex_code), 32'd8);
    ws_valid   = 1'b1;
    ws_ex_code = 5'd4;
    ws_eret    = 1'b1;
    cp0_status = 32'h0000ff01;
    cp0_cause  = 32'h0000ff00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_strobes_idle($sformatf("drn.s%0d", k));
      chk($sformatf("drn.rvalid%0d", k), 32'(redirect_valid), 32'd0);
      chk($sformatf("drn.flush%0d", k),  32'(flush),          32'd1);
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("drn.rvalid", 32'(redirect_valid), 32'd1);
    chk("drn.rpc",    redirect_pc,         32'hbfc00380);
    chk_strobes_idle("drn.s2");
    clear_ws();
    @(negedge clk);
    chk_all_idle("drn.done");

    // Asynchronous reset while a redirect is offered.
    redirect_ready = 1'b0;
    commit_syscall(32'hbfc00500);
    @(negedge clk);
    @(negedge clk);
    chk("rst.rvalid", 32'(redirect_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk_all_idle("rst.now");
    chk("rst.rpc", redirect_pc, 32'd0);
    @(negedge clk);
    resetn         = 1'b1;
    redirect_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_all_idle($sformatf("rst.after%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
